// File: rtl/cacheline_adapter.sv
// cacheline_adapter: converts single 256-bit cacheline read/write requests
// into 4-beat 64-bit bursts on the burst-memory port and reassembles read
// bursts into a full line. One transaction outstanding at a time.
module cacheline_adapter #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   // cache-facing side
   input  logic [31:0]       dfp_addr_i,
   input  logic              dfp_read_i,
   input  logic              dfp_write_i,
   input  logic [LINE_W-1:0] dfp_wdata_i,
   output logic              dfp_ready_o,
   output logic [31:0]       dfp_raddr_o,
   output logic [LINE_W-1:0] dfp_rdata_o,
   output logic              dfp_rvalid_o,
   // burst-memory side
   output logic [31:0]       bmem_addr_o,
   output logic              bmem_read_o,
   output logic              bmem_write_o,
   output logic [DATA_W-1:0] bmem_wdata_o,
   input  logic              bmem_ready_i,
   input  logic [31:0]       bmem_raddr_i,
   input  logic [DATA_W-1:0] bmem_rdata_i,
   input  logic              bmem_rvalid_i
);

   localparam int unsigned BEATS      = LINE_W / DATA_W;
   localparam int unsigned CNT_W      = $clog2(BEATS);
   localparam int unsigned OFF_W      = $clog2(DATA_W);
   localparam int unsigned LINE_BYTES = LINE_W / 8;
   localparam logic [31:0] ADDR_MASK  = ~(32'(LINE_BYTES) - 32'd1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_BURST = 3'd1,
      RD_REQ   = 3'd2,
      RD_WAIT  = 3'd3,
      RD_RESP  = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [31:0]         addr_q, addr_d;
   logic [LINE_W-1:0]   wdata_q, wdata_d;
   logic [LINE_W-1:0]   line_q, line_d;

   logic                dfp_ready_q, dfp_ready_d;
   logic                dfp_rvalid_q, dfp_rvalid_d;
   logic [31:0]         dfp_raddr_q, dfp_raddr_d;
   logic [LINE_W-1:0]   dfp_rdata_q, dfp_rdata_d;
   logic [31:0]         bmem_addr_q, bmem_addr_d;
   logic                bmem_read_q, bmem_read_d;
   logic                bmem_write_q, bmem_write_d;
   logic [DATA_W-1:0]   bmem_wdata_q, bmem_wdata_d;

   logic [31:0]         req_addr;
   logic                beat_match;

   assign req_addr   = dfp_addr_i & ADDR_MASK;
   assign beat_match = bmem_rvalid_i && (bmem_raddr_i == addr_q);

   // Next-state and next-output decode; outputs are registered from here.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      line_d       = line_q;
      dfp_ready_d  = 1'b0;
      dfp_rvalid_d = 1'b0;
      dfp_raddr_d  = dfp_raddr_q;
      dfp_rdata_d  = dfp_rdata_q;
      bmem_addr_d  = bmem_addr_q;
      bmem_read_d  = 1'b0;
      bmem_write_d = 1'b0;
      bmem_wdata_d = bmem_wdata_q;

      unique case (state_q)
         IDLE: begin
            if (dfp_write_i) begin
               // a simultaneous read is dropped; caches never issue both
               addr_d       = req_addr;
               wdata_d      = dfp_wdata_i;
               cnt_d        = '0;
               state_d      = WR_BURST;
               bmem_addr_d  = req_addr;
               bmem_write_d = 1'b1;
               bmem_wdata_d = dfp_wdata_i[DATA_W-1:0];
            end else if (dfp_read_i) begin
               addr_d      = req_addr;
               state_d     = RD_REQ;
               bmem_addr_d = req_addr;
               bmem_read_d = 1'b1;
            end else begin
               dfp_ready_d = 1'b1;
            end
         end

         WR_BURST: begin
            bmem_write_d = 1'b1;
            if (bmem_ready_i) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BEAT) begin
                  state_d      = IDLE;
                  bmem_write_d = 1'b0;
                  dfp_ready_d  = 1'b1;
               end else begin
                  bmem_wdata_d = wdata_q[{cnt_d, OFF_W'(0)} +: DATA_W];
               end
            end
         end

         RD_REQ: begin
            if (bmem_ready_i) begin
               state_d = RD_WAIT;
               cnt_d   = '0;
            end else begin
               bmem_read_d = 1'b1;
            end
         end

         RD_WAIT: begin
            if (beat_match) begin
               line_d[{cnt_q, OFF_W'(0)} +: DATA_W] = bmem_rdata_i;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BEAT) begin
                  state_d      = RD_RESP;
                  dfp_rvalid_d = 1'b1;
                  dfp_rdata_d  = line_d;
                  dfp_raddr_d  = addr_q;
               end
            end
         end

         RD_RESP: begin
            state_d     = IDLE;
            dfp_ready_d = 1'b1;
         end

         default: begin
            state_d     = IDLE;
            dfp_ready_d = 1'b1;
         end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         line_q       <= '0;
         dfp_ready_q  <= 1'b0;
         dfp_rvalid_q <= 1'b0;
         dfp_raddr_q  <= '0;
         dfp_rdata_q  <= '0;
         bmem_addr_q  <= '0;
         bmem_read_q  <= 1'b0;
         bmem_write_q <= 1'b0;
         bmem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         line_q       <= line_d;
         dfp_ready_q  <= dfp_ready_d;
         dfp_rvalid_q <= dfp_rvalid_d;
         dfp_raddr_q  <= dfp_raddr_d;
         dfp_rdata_q  <= dfp_rdata_d;
         bmem_addr_q  <= bmem_addr_d;
         bmem_read_q  <= bmem_read_d;
         bmem_write_q <= bmem_write_d;
         bmem_wdata_q <= bmem_wdata_d;
      end
   end

   assign dfp_ready_o  = dfp_ready_q;
   assign dfp_rvalid_o = dfp_rvalid_q;
   assign dfp_raddr_o  = dfp_raddr_q;
   assign dfp_rdata_o  = dfp_rdata_q;
   assign bmem_addr_o  = bmem_addr_q;
   assign bmem_read_o  = bmem_read_q;
   assign bmem_write_o = bmem_write_q;
   assign bmem_wdata_o = bmem_wdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: table of read/write transactions
// applied back-to-back, plus a hand-written reset-mid-read sequence.
module tb_cacheline_adapter;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned LINE_W = 256;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [31:0]       dfp_addr_i;
   logic              dfp_read_i;
   logic              dfp_write_i;
   logic [LINE_W-1:0] dfp_wdata_i;
   logic              dfp_ready_o;
   logic [31:0]       dfp_raddr_o;
   logic [LINE_W-1:0] dfp_rdata_o;
   logic              dfp_rvalid_o;
   logic [31:0]       bmem_addr_o;
   logic              bmem_read_o;
   logic              bmem_write_o;
   logic [DATA_W-1:0] bmem_wdata_o;
   logic              bmem_ready_i;
   logic [31:0]       bmem_raddr_i;
   logic [DATA_W-1:0] bmem_rdata_i;
   logic              bmem_rvalid_i;

   int n_checks = 0;
   int n_fail   = 0;
   int rv_count = 0;

   cacheline_adapter #(.DATA_W(DATA_W), .LINE_W(LINE_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .dfp_addr_i   (dfp_addr_i),
      .dfp_read_i   (dfp_read_i),
      .dfp_write_i  (dfp_write_i),
      .dfp_wdata_i  (dfp_wdata_i),
      .dfp_ready_o  (dfp_ready_o),
      .dfp_raddr_o  (dfp_raddr_o),
      .dfp_rdata_o  (dfp_rdata_o),
      .dfp_rvalid_o (dfp_rvalid_o),
      .bmem_addr_o  (bmem_addr_o),
      .bmem_read_o  (bmem_read_o),
      .bmem_write_o (bmem_write_o),
      .bmem_wdata_o (bmem_wdata_o),
      .bmem_ready_i (bmem_ready_i),
      .bmem_raddr_i (bmem_raddr_i),
      .bmem_rdata_i (bmem_rdata_i),
      .bmem_rvalid_i(bmem_rvalid_i)
   );

   always #5 clk = ~clk;

   // count every cycle the response strobe is high
   always @(posedge clk) begin
      if (dfp_rvalid_o) rv_count <= rv_count + 1;
   end

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [255:0] line;
      logic [31:0] exp_addr;
      int          bp_beat;
      int          bp_n;
      int          req_bp;
      bit          gap;
      bit          stray;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // called at a negedge with the adapter idle; returns at the negedge where ready is back
   task automatic do_write(input logic [31:0] a, input logic [255:0] l, input logic [31:0] ea,
                           input int bp_beat, input int bp_n);
      int cyc;
      int stall;
      check("wr_ready_before", 256'(dfp_ready_o), 256'(1));
      dfp_write_i = 1'b1;
      dfp_addr_i  = a;
      dfp_wdata_i = l;
      @(negedge clk);
      dfp_write_i = 1'b0;
      dfp_wdata_i = '0;
      dfp_addr_i  = '0;
      cyc = 1;
      for (int k = 0; k < 4; k++) begin
         stall = 0;
         while (1) begin
            check("wr_valid", 256'(bmem_write_o), 256'(1));
            check("wr_noread", 256'(bmem_read_o), 256'(0));
            check("wr_busy", 256'(dfp_ready_o), 256'(0));
            check("wr_addr", 256'(bmem_addr_o), 256'(ea));
            check("wr_beat", 256'(bmem_wdata_o), 256'(l[64*k +: 64]));
            if (k == bp_beat && stall < bp_n) begin
               bmem_ready_i = 1'b0;
               stall++;
            end else begin
               bmem_ready_i = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (bmem_ready_i) break;
         end
      end
      bmem_ready_i = 1'b1;
      check("wr_done_ready", 256'(dfp_ready_o), 256'(1));
      check("wr_done_idle", 256'(bmem_write_o), 256'(0));
      check("wr_latency", 256'(cyc), 256'(5 + bp_n));
   endtask

   task automatic do_read(input logic [31:0] a, input logic [255:0] l, input logic [31:0] ea,
                          input int req_bp, input bit gap, input bit stray);
      int rv0;
      check("rd_ready_before", 256'(dfp_ready_o), 256'(1));
      dfp_read_i = 1'b1;
      dfp_addr_i = a;
      @(negedge clk);
      dfp_read_i = 1'b0;
      dfp_addr_i = '0;
      for (int s = 0; s <= req_bp; s++) begin
         check("rd_req", 256'(bmem_read_o), 256'(1));
         check("rd_req_addr", 256'(bmem_addr_o), 256'(ea));
         check("rd_busy", 256'(dfp_ready_o), 256'(0));
         bmem_ready_i = (s == req_bp);
         @(negedge clk);
      end
      bmem_ready_i = 1'b1;
      check("rd_req_drop", 256'(bmem_read_o), 256'(0));
      rv0 = rv_count;
      for (int k = 0; k < 4; k++) begin
         if (gap && (k % 2) == 1) begin
            bmem_rvalid_i = 1'b0;
            repeat (2) @(negedge clk);
         end
         if (stray && k == 2) begin
            bmem_rvalid_i = 1'b1;
            bmem_raddr_i  = 32'hDEAD_BEE0;
            bmem_rdata_i  = '1;
            @(negedge clk);
         end
         bmem_rvalid_i = 1'b1;
         bmem_raddr_i  = ea;
         bmem_rdata_i  = l[64*k +: 64];
         @(negedge clk);
         bmem_rvalid_i = 1'b0;
         bmem_raddr_i  = '0;
         bmem_rdata_i  = '0;
      end
      check("rd_rvalid", 256'(dfp_rvalid_o), 256'(1));
      check("rd_rdata", dfp_rdata_o, l);
      check("rd_raddr", 256'(dfp_raddr_o), 256'(ea));
      check("rd_resp_busy", 256'(dfp_ready_o), 256'(0));
      @(negedge clk);
      check("rd_rvalid_drop", 256'(dfp_rvalid_o), 256'(0));
      check("rd_done_ready", 256'(dfp_ready_o), 256'(1));
      check("rd_rdata_hold", dfp_rdata_o, l);
      check("rd_rvalid_once", 256'(rv_count - rv0), 256'(1));
   endtask

   initial begin
      int rv0;
      logic [255:0] fresh;

      vecs[0] = '{1'b0, 32'h1234_5678,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                  32'h1234_5660, 0, 0, 0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 32'h0000_0040,
                  {64'hA000_0000_0000_0003, 64'hA000_0000_0000_0002,
                   64'hA000_0000_0000_0001, 64'hA000_0000_0000_0000},
                  32'h0000_0040, 0, 0, 0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 32'h0000_1FFF,
                  {64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978,
                   64'hCAFE_F00D_0000_0001, 64'h5555_AAAA_5555_AAAA},
                  32'h0000_1FE0, 2, 3, 0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 32'hFFFF_FFFF,
                  {64'h0123_4567_89AB_CDEF, 64'h1357_9BDF_0246_8ACE,
                   64'hDEAD_BEEF_0000_0000, 64'h0000_0000_BEEF_DEAD},
                  32'hFFFF_FFE0, 0, 0, 5, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 32'h8000_0010,
                  {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2,
                   64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0},
                  32'h8000_0000, 0, 0, 0, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 32'h0000_0100,
                  {64'hD1D1_0000_0000_0004, 64'hD1D1_0000_0000_0003,
                   64'hD1D1_0000_0000_0002, 64'hD1D1_0000_0000_0001},
                  32'h0000_0100, 0, 0, 0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 32'h0000_0200,
                  {64'hE2E2_0000_0000_0004, 64'hE2E2_0000_0000_0003,
                   64'hE2E2_0000_0000_0002, 64'hE2E2_0000_0000_0001},
                  32'h0000_0200, 0, 0, 0, 1'b0, 1'b0};

      dfp_addr_i    = '0;
      dfp_read_i    = 1'b0;
      dfp_write_i   = 1'b0;
      dfp_wdata_i   = '0;
      bmem_ready_i  = 1'b1;
      bmem_raddr_i  = '0;
      bmem_rdata_i  = '0;
      bmem_rvalid_i = 1'b0;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", 256'(dfp_ready_o), 256'(0));
      check("rst_rvalid", 256'(dfp_rvalid_o), 256'(0));
      check("rst_bread", 256'(bmem_read_o), 256'(0));
      check("rst_bwrite", 256'(bmem_write_o), 256'(0));
      check("rst_baddr", 256'(bmem_addr_o), 256'(0));
      check("rst_bwdata", 256'(bmem_wdata_o), 256'(0));
      check("rst_raddr", 256'(dfp_raddr_o), 256'(0));
      check("rst_rdata", dfp_rdata_o, 256'(0));
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 256'(dfp_ready_o), 256'(1));

      // table transactions, each issued the cycle ready returns
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].wr)
            do_write(vecs[i].addr, vecs[i].line, vecs[i].exp_addr, vecs[i].bp_beat, vecs[i].bp_n);
         else
            do_read(vecs[i].addr, vecs[i].line, vecs[i].exp_addr,
                    vecs[i].req_bp, vecs[i].gap, vecs[i].stray);
      end

      // reset in the middle of a read after two beats
      dfp_read_i = 1'b1;
      dfp_addr_i = 32'h0000_0A04;
      @(negedge clk);
      dfp_read_i = 1'b0;
      bmem_ready_i = 1'b1;
      check("rr_req", 256'(bmem_read_o), 256'(1));
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         bmem_rvalid_i = 1'b1;
         bmem_raddr_i  = 32'h0000_0A00;
         bmem_rdata_i  = 64'h7777_0000_0000_0000 | 64'(k);
         @(negedge clk);
      end
      bmem_rvalid_i = 1'b0;
      rv0 = rv_count;
      rst = 1'b1;
      @(negedge clk);
      check("rr_rst_ready", 256'(dfp_ready_o), 256'(0));
      check("rr_rst_rvalid", 256'(dfp_rvalid_o), 256'(0));
      rst = 1'b0;
      @(negedge clk);
      check("rr_ready", 256'(dfp_ready_o), 256'(1));
      // late beats arriving while idle must be ignored
      for (int k = 2; k < 4; k++) begin
         bmem_rvalid_i = 1'b1;
         bmem_raddr_i  = 32'h0000_0A00;
         bmem_rdata_i  = 64'h7777_0000_0000_0000 | 64'(k);
         @(negedge clk);
      end
      bmem_rvalid_i = 1'b0;
      @(negedge clk);
      check("rr_no_rvalid", 256'(rv_count - rv0), 256'(0));
      check("rr_no_bread", 256'(bmem_read_o), 256'(0));
      check("rr_no_bwrite", 256'(bmem_write_o), 256'(0));
      check("rr_idle_ready", 256'(dfp_ready_o), 256'(1));
      fresh = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
               64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
      do_read(32'h0000_0A1F, fresh, 32'h0000_0A00, 1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
